// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back stage has priority, and a small
// FIFO of secondary writes drains into idle port cycles, with a starvation-forced stall.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [3:0]               wb_dest,
  input  logic [31:0]              wb_value,
  input  logic                     sec_valid,
  input  logic [3:0]               sec_dest,
  input  logic [31:0]              sec_value,
  output logic                     sec_ready,
  output logic                     rf_we,
  output logic [3:0]               rf_dest,
  output logic [31:0]              rf_data,
  output logic                     stall_pipe,
  input  logic [3:0]               src1,
  input  logic [3:0]               src2,
  output logic                     pend_hit1,
  output logic                     pend_hit2,
  output logic [$clog2(DEPTH):0]   sec_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [3:0]       dest_q  [DEPTH];
  logic [31:0]      value_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WW-1:0]    wait_q, wait_d;

  logic empty, full, push, pop, grant_pri;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign sec_ready  = !full;
  assign push       = sec_valid && !full;
  assign stall_pipe = (wait_q == WW'(MAX_WAIT));
  assign grant_pri  = wb_en && !stall_pipe;
  assign pop        = !grant_pri && !empty;
  assign sec_count  = count_q;

  always_comb begin
    rf_we   = 1'b0;
    rf_dest = '0;
    rf_data = '0;
    if (grant_pri) begin
      rf_we   = 1'b1;
      rf_dest = wb_dest;
      rf_data = wb_value;
    end else if (pop) begin
      rf_we   = 1'b1;
      rf_dest = dest_q[rd_ptr_q];
      rf_data = value_q[rd_ptr_q];
    end
  end

  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && dest_q[i] == src1) pend_hit1 = 1'b1;
      if (valid_q[i] && dest_q[i] == src2) pend_hit2 = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Only a head that was present and passed over this cycle ages the counter.
  always_comb begin
    wait_d = wait_q;
    if (pop || count_d == '0) begin
      wait_d = '0;
    end else if (!empty && !stall_pipe) begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      valid_q  <= '0;
    end else begin
      count_q <= count_d;
      wait_q  <= wait_d;
      if (push) begin
        wr_ptr_q          <= wr_ptr_q + AW'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q          <= rd_ptr_q + AW'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by valid_q and count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr_q]  <= sec_dest;
      value_q[wr_ptr_q] <= sec_value;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: a queue-based reference model predicts every write; a negedge
// monitor pops expected writes whenever the DUT drives rf_we.
module tb_rf_wb_arbiter;

  localparam int unsigned DEPTH    = 2;
  localparam int unsigned MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_dest = '0;
  logic [31:0] wb_value = '0;
  logic        sec_valid = 1'b1;
  logic [3:0]  sec_dest = 4'd9;
  logic [31:0] sec_value = 32'h99;
  logic        sec_ready, rf_we, stall_pipe, pend_hit1, pend_hit2;
  logic [3:0]  rf_dest;
  logic [31:0] rf_data;
  logic [3:0]  src1 = '0, src2 = '0;
  logic [$clog2(DEPTH):0] sec_count;

  rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .sec_valid(sec_valid), .sec_dest(sec_dest), .sec_value(sec_value), .sec_ready(sec_ready),
    .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data), .stall_pipe(stall_pipe),
    .src1(src1), .src2(src2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .sec_count(sec_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } wr_t;

  wr_t m_q[$];    // model of buffered secondary writes, head first
  wr_t exp_q[$];  // writes expected at the register-file port, in order
  int  m_wait = 0;
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, check at negedge, advance model at posedge.
  task automatic step(input logic we, input logic [3:0] wd, input logic [31:0] wv,
                      input logic sv, input logic [3:0] sd, input logic [31:0] svl,
                      input logic [3:0] s1, input logic [3:0] s2,
                      output logic accepted, output logic stalled);
    bit  stall_e, ready_e, pop_e, we_e, hit1_e, hit2_e, had;
    wr_t w;
    wb_en = we; wb_dest = wd; wb_value = wv;
    sec_valid = sv; sec_dest = sd; sec_value = svl;
    src1 = s1; src2 = s2;
    stall_e = (m_wait == MAX_WAIT);
    ready_e = (m_q.size() < DEPTH);
    pop_e = 0;
    we_e = 0;
    if (!stall_e && we) begin
      w.dest = wd; w.data = wv;
      exp_q.push_back(w);
      we_e = 1;
    end else if (m_q.size() > 0) begin
      exp_q.push_back(m_q[0]);
      pop_e = 1;
      we_e = 1;
    end
    hit1_e = 0;
    hit2_e = 0;
    foreach (m_q[i]) begin
      if (m_q[i].dest == s1) hit1_e = 1;
      if (m_q[i].dest == s2) hit2_e = 1;
    end
    accepted = sv && ready_e;
    stalled = stall_e;
    @(negedge clk);
    chk("sec_ready", 32'(sec_ready), 32'(ready_e));
    chk("stall_pipe", 32'(stall_pipe), 32'(stall_e));
    chk("sec_count", 32'(sec_count), m_q.size());
    chk("pend_hit1", 32'(pend_hit1), 32'(hit1_e));
    chk("pend_hit2", 32'(pend_hit2), 32'(hit2_e));
    chk("rf_we", 32'(rf_we), 32'(we_e));
    @(posedge clk);
    had = (m_q.size() > 0);
    if (pop_e) void'(m_q.pop_front());
    if (accepted) begin
      w.dest = sd; w.data = svl;
      m_q.push_back(w);
    end
    if (pop_e || m_q.size() == 0) m_wait = 0;
    else if (had && m_wait < MAX_WAIT) m_wait++;
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got dest %0d data 0x%0h, expected no write at %0t",
                   rf_dest, rf_data, $time);
        end else begin
          w = exp_q.pop_front();
          chk("rf_dest", 32'(rf_dest), 32'(w.dest));
          chk("rf_data", rf_data, w.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc, stl;
    logic pend;
    logic [3:0] pd, cwd;
    logic [31:0] pv, cwv;
    logic cwe;
    int tries;

    // Reset held for two cycles while a secondary request is offered.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset sec_ready", 32'(sec_ready), 32'd1);
    chk("reset stall_pipe", 32'(stall_pipe), 32'd0);
    chk("reset sec_count", 32'(sec_count), 32'd0);
    chk("reset rf_dest", 32'(rf_dest), 32'd0);
    chk("reset rf_data", rf_data, 32'd0);
    rst = 1'b0;
    sec_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset sec_count", 32'(sec_count), 32'd0);

    // Idle drain.
    step(0, 0, 0, 1, 4'd5, 32'hDEADBEEF, 0, 0, acc, stl);
    repeat (2) step(0, 0, 0, 0, 0, 0, 4'd5, 0, acc, stl);

    // Starvation under a continuous primary stream.
    step(1, 4'd2, 32'h11, 1, 4'd7, 32'h77, 0, 0, acc, stl);
    repeat (7) step(1, 4'd2, 32'h11, 0, 0, 0, 4'd7, 0, acc, stl);

    // Full / backpressure.
    step(1, 4'd1, 32'h100, 1, 4'd10, 32'hA, 0, 0, acc, stl);
    step(1, 4'd1, 32'h100, 1, 4'd11, 32'hB, 0, 0, acc, stl);
    step(1, 4'd1, 32'h100, 1, 4'd14, 32'hC, 0, 0, acc, stl);
    acc = 0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(0, 0, 0, 1, 4'd14, 32'hC, 0, 0, acc, stl);
      tries++;
    end
    chk("third entry accepted", 32'(acc), 32'd1);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, acc, stl);

    // Hazard flags.
    step(1, 4'd1, 32'h5, 1, 4'd3, 32'h33, 4'd3, 4'd4, acc, stl);
    step(1, 4'd1, 32'h6, 0, 0, 0, 4'd3, 4'd4, acc, stl);
    repeat (3) step(0, 0, 0, 0, 0, 0, 4'd3, 4'd4, acc, stl);

    // Asynchronous reset with two entries buffered.
    step(1, 4'd1, 32'h7, 1, 4'd12, 32'hC12, 0, 0, acc, stl);
    step(1, 4'd1, 32'h8, 1, 4'd13, 32'hC13, 0, 0, acc, stl);
    wb_en = 1'b0;
    sec_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset rf_we", 32'(rf_we), 32'd0);
    chk("midreset sec_count", 32'(sec_count), 32'd0);
    chk("midreset sec_ready", 32'(sec_ready), 32'd1);
    m_q.delete();
    m_wait = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (4) step(0, 0, 0, 0, 0, 0, 4'd12, 4'd13, acc, stl);

    // Randomized traffic; the requester holds a request until accepted and the
    // pipeline re-presents its write after a stall.
    pend = 0; pd = 0; pv = 0;
    cwe = 0; cwd = 0; cwv = 0;
    stl = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && ($urandom % 3) == 0) begin
        pend = 1;
        pd = 4'($urandom);
        pv = $urandom;
      end
      if (!stl) begin
        cwe = ((i / 50) % 2 == 1) ? (($urandom % 10) != 0) : (($urandom % 10) < 4);
        cwd = 4'($urandom);
        cwv = $urandom;
      end
      step(cwe, cwd, cwv, pend, pd, pv, 4'($urandom), 4'($urandom), acc, stl);
      if (acc) pend = 0;
    end
    repeat (DEPTH + 2) step(0, 0, 0, 0, 0, 0, 0, 0, acc, stl);
    chk("expected writes all seen", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
